// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: mode/adjust sequencer for the sec/min/hour/day/month/year
// counter chain.
//   RUN : forwards tick_s as tick_en and holds run_en high so the counters cascade.
//   SET : freezes the cascade and selects one field. The up/down buttons (press,
//         then hold auto-repeat) become one-cycle step pulses on the en_* line of
//         the selected field, qualified by up/down. The selected field blinks, and
//         the block drops back to RUN after TIMEOUT_S seconds without a press.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   tick_ms, tick_s             1 kHz / 1 Hz single-cycle strobes
//   btn_mode, btn_up, btn_down  debounced button levels, high = pressed
//   run_en, tick_en, sec_clr    cascade enable, gated 1 Hz tick, seconds clear
//   en_min..en_yr, up, down     one-hot step pulse and its direction
//   field_sel, field_blank      selected field (0 = RUN), blank selected digits
module clock_set_ctrl #(
  parameter int HOLD_MS   = 500,
  parameter int REPEAT_MS = 150,
  parameter int BLINK_MS  = 250,
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_ms,
  input  logic       tick_s,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       run_en,
  output logic       tick_en,
  output logic       sec_clr,
  output logic       en_min,
  output logic       en_hour,
  output logic       en_day,
  output logic       en_mo,
  output logic       en_yr,
  output logic       up,
  output logic       down,
  output logic [2:0] field_sel,
  output logic       field_blank
);

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_MIN  = 3'd1,
    S_HOUR = 3'd2,
    S_DAY  = 3'd3,
    S_MON  = 3'd4,
    S_YEAR = 3'd5
  } state_t;

  localparam int RPT_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam int BW      = $clog2(BLINK_MS + 1);
  localparam int IW      = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam int IDLE_LAST_I = (TIMEOUT_S > 0) ? TIMEOUT_S - 1 : 0;

  localparam logic [RW-1:0] HOLD_LAST   = RW'(HOLD_MS - 1);
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_MS - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_MS - 1);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(IDLE_LAST_I);

  state_t        state, nxt_state;
  logic          mode_q, up_q, down_q;
  logic [RW-1:0] rpt_cnt, nxt_rpt;
  logic          rpt_ph, nxt_rpt_ph;   // 0: waiting out HOLD_MS, 1: repeating
  logic [BW-1:0] blink_cnt, nxt_blink;
  logic          blank_q, nxt_blank;
  logic [IW-1:0] idle_cnt, nxt_idle;
  logic          step, step_up, clr_sec;
  logic          mode_p, up_p, down_p;

  assign mode_p = btn_mode & ~mode_q;
  assign up_p   = btn_up   & ~up_q;
  assign down_p = btn_down & ~down_q;

  always_comb begin
    nxt_state  = state;
    nxt_rpt    = rpt_cnt;
    nxt_rpt_ph = rpt_ph;
    nxt_blink  = blink_cnt;
    nxt_blank  = blank_q;
    nxt_idle   = idle_cnt;
    step       = 1'b0;
    step_up    = 1'b0;
    clr_sec    = 1'b0;

    if (mode_p) begin
      // Mode press wins over any up/down activity in the same cycle.
      case (state)
        S_RUN:   begin nxt_state = S_MIN; clr_sec = 1'b1; end
        S_MIN:   nxt_state = S_HOUR;
        S_HOUR:  nxt_state = S_DAY;
        S_DAY:   nxt_state = S_MON;
        S_MON:   nxt_state = S_YEAR;
        default: nxt_state = S_RUN;
      endcase
      nxt_rpt    = '0;
      nxt_rpt_ph = 1'b0;
      nxt_blink  = '0;
      nxt_blank  = 1'b0;
      nxt_idle   = '0;
    end else if (state != S_RUN) begin
      // Step generation: only while exactly one direction button is held.
      if (btn_up == btn_down) begin
        nxt_rpt    = '0;
        nxt_rpt_ph = 1'b0;
      end else if (up_p || down_p) begin
        step       = 1'b1;
        step_up    = up_p;
        nxt_rpt    = '0;
        nxt_rpt_ph = 1'b0;
      end else if (tick_ms) begin
        if (rpt_cnt == (rpt_ph ? REPEAT_LAST : HOLD_LAST)) begin
          step       = 1'b1;
          step_up    = btn_up;
          nxt_rpt    = '0;
          nxt_rpt_ph = 1'b1;
        end else begin
          nxt_rpt = rpt_cnt + 1'b1;
        end
      end

      // Idle timeout; a timeout suppresses a coincident auto-repeat step.
      if (up_p || down_p) begin
        nxt_idle = '0;
      end else if (tick_s && TIMEOUT_S != 0) begin
        if (idle_cnt == IDLE_LAST) begin
          nxt_state = S_RUN;
          nxt_idle  = '0;
          step      = 1'b0;
        end else begin
          nxt_idle = idle_cnt + 1'b1;
        end
      end

      if (nxt_state == S_RUN || step) begin
        nxt_blink = '0;
        nxt_blank = 1'b0;
      end else if (tick_ms) begin
        if (blink_cnt == BLINK_LAST) begin
          nxt_blink = '0;
          nxt_blank = ~blank_q;
        end else begin
          nxt_blink = blink_cnt + 1'b1;
        end
      end
    end else begin
      nxt_rpt    = '0;
      nxt_rpt_ph = 1'b0;
      nxt_blink  = '0;
      nxt_blank  = 1'b0;
      nxt_idle   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      mode_q      <= 1'b1;
      up_q        <= 1'b1;
      down_q      <= 1'b1;
      rpt_cnt     <= '0;
      rpt_ph      <= 1'b0;
      blink_cnt   <= '0;
      blank_q     <= 1'b0;
      idle_cnt    <= '0;
      run_en      <= 1'b1;
      tick_en     <= 1'b0;
      sec_clr     <= 1'b0;
      en_min      <= 1'b0;
      en_hour     <= 1'b0;
      en_day      <= 1'b0;
      en_mo       <= 1'b0;
      en_yr       <= 1'b0;
      up          <= 1'b0;
      down        <= 1'b0;
      field_sel   <= '0;
      field_blank <= 1'b0;
    end else begin
      state       <= nxt_state;
      mode_q      <= btn_mode;
      up_q        <= btn_up;
      down_q      <= btn_down;
      rpt_cnt     <= nxt_rpt;
      rpt_ph      <= nxt_rpt_ph;
      blink_cnt   <= nxt_blink;
      blank_q     <= nxt_blank;
      idle_cnt    <= nxt_idle;
      run_en      <= (nxt_state == S_RUN);
      // Only forward ticks that arrive while staying in RUN.
      tick_en     <= tick_s && state == S_RUN && nxt_state == S_RUN;
      sec_clr     <= clr_sec;
      en_min      <= step && state == S_MIN;
      en_hour     <= step && state == S_HOUR;
      en_day      <= step && state == S_DAY;
      en_mo       <= step && state == S_MON;
      en_yr       <= step && state == S_YEAR;
      up          <= step && step_up;
      down        <= step && !step_up;
      field_sel   <= nxt_state;
      field_blank <= nxt_blank;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick_ms, tick_s, btn_mode, btn_up, btn_down;
  logic       run_en, tick_en, sec_clr, en_min, en_hour, en_day, en_mo, en_yr, up, down;
  logic [2:0] field_sel;
  logic       field_blank;
  logic       run_en2, tick_en2, sec_clr2, en_min2, en_hour2, en_day2, en_mo2, en_yr2, up2, down2;
  logic [2:0] field_sel2;
  logic       field_blank2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  clock_set_ctrl #(.HOLD_MS(500), .REPEAT_MS(150), .BLINK_MS(250), .TIMEOUT_S(30)) dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .tick_s(tick_s),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .run_en(run_en), .tick_en(tick_en), .sec_clr(sec_clr),
    .en_min(en_min), .en_hour(en_hour), .en_day(en_day), .en_mo(en_mo), .en_yr(en_yr),
    .up(up), .down(down), .field_sel(field_sel), .field_blank(field_blank)
  );

  clock_set_ctrl #(.HOLD_MS(500), .REPEAT_MS(150), .BLINK_MS(250), .TIMEOUT_S(0)) dut_nto (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .tick_s(tick_s),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .run_en(run_en2), .tick_en(tick_en2), .sec_clr(sec_clr2),
    .en_min(en_min2), .en_hour(en_hour2), .en_day(en_day2), .en_mo(en_mo2), .en_yr(en_yr2),
    .up(up2), .down(down2), .field_sel(field_sel2), .field_blank(field_blank2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] en_sum();
    return 32'(en_min) + 32'(en_hour) + 32'(en_day) + 32'(en_mo) + 32'(en_yr);
  endfunction

  initial begin
    int n_steps;
    int first_i;
    int last_i;
    int bad;

    rst = 1'b1; tick_ms = 1'b0; tick_s = 1'b0;
    btn_mode = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    cyc(); cyc();
    chk("rst_run_en", run_en, 1);
    chk("rst_field_sel", field_sel, 0);
    chk("rst_tick_en", tick_en, 0);
    chk("rst_sec_clr", sec_clr, 0);
    chk("rst_blank", field_blank, 0);

    // Mode held through reset is not a press.
    rst = 1'b0;
    cyc();
    chk("held_mode_no_press", field_sel, 0);
    btn_mode = 1'b0;
    cyc();

    tick_s = 1'b1; cyc(); tick_s = 1'b0;
    chk("run_tick_en", tick_en, 1);
    cyc();
    chk("run_tick_en_off", tick_en, 0);

    // T1: RUN -> MIN
    btn_mode = 1'b1; cyc(); btn_mode = 1'b0;
    chk("t1_field_sel", field_sel, 1);
    chk("t1_sec_clr", sec_clr, 1);
    chk("t1_run_en", run_en, 0);
    tick_s = 1'b1; cyc(); tick_s = 1'b0;
    chk("t1_sec_clr_pulse", sec_clr, 0);
    chk("t1_tick_en_set", tick_en, 0);

    // T2: single up / down steps in MIN
    btn_up = 1'b1; cyc();
    chk("t2_up_en_min", en_min, 1);
    chk("t2_up_up", up, 1);
    chk("t2_up_down", down, 0);
    cyc();
    chk("t2_up_one_cycle", en_min, 0);
    btn_up = 1'b0; cyc();
    btn_down = 1'b1; cyc();
    chk("t2_dn_en_min", en_min, 1);
    chk("t2_dn_down", down, 1);
    chk("t2_dn_up", up, 0);
    btn_down = 1'b0; cyc();
    chk("t2_dn_one_cycle", en_min, 0);

    // MIN -> HOUR
    btn_mode = 1'b1; cyc(); btn_mode = 1'b0;
    chk("hour_field_sel", field_sel, 2);
    chk("hour_no_sec_clr", sec_clr, 0);
    cyc();

    // T3: hold up through 1000 tick_ms
    btn_up = 1'b1; cyc();
    chk("t3_press_step", en_hour, 1);
    n_steps = 0; first_i = -1; last_i = -1;
    tick_ms = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      cyc();
      if (en_hour) begin
        n_steps++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
    end
    tick_ms = 1'b0; btn_up = 1'b0;
    chk("t3_repeat_count", n_steps, 4);
    chk("t3_first_repeat", first_i, 500);
    chk("t3_last_repeat", last_i, 950);
    cyc();

    // HOUR -> DAY, then blink half-period
    btn_mode = 1'b1; cyc(); btn_mode = 1'b0;
    chk("day_field_sel", field_sel, 3);
    cyc();
    tick_ms = 1'b1;
    for (int i = 0; i < 249; i++) cyc();
    chk("blink_before", field_blank, 0);
    cyc();
    chk("blink_after", field_blank, 1);
    tick_ms = 1'b0;

    // T4: mode and up in the same cycle
    btn_mode = 1'b1; btn_up = 1'b1; cyc(); btn_mode = 1'b0;
    chk("t4_field_sel", field_sel, 4);
    chk("t4_no_step", en_sum(), 0);
    chk("t4_no_up", up, 0);
    chk("t4_blank_cleared", field_blank, 0);
    btn_down = 1'b1; cyc();
    chk("t4_both_no_step", en_sum(), 0);
    bad = 0;
    tick_ms = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cyc();
      if (en_sum() != 0) bad++;
    end
    tick_ms = 1'b0;
    chk("t4_both_held_steps", bad, 0);
    btn_up = 1'b0; btn_down = 1'b0; cyc();

    // T5: idle timeout from MON
    for (int i = 0; i < 29; i++) begin
      tick_s = 1'b1; cyc(); tick_s = 1'b0; cyc();
    end
    chk("t5_before_timeout", field_sel, 4);
    tick_s = 1'b1; cyc(); tick_s = 1'b0;
    chk("t5_timeout_field", field_sel, 0);
    chk("t5_timeout_run_en", run_en, 1);
    chk("t5_timeout_no_sec_clr", sec_clr, 0);
    chk("t5_timeout_tick_en", tick_en, 0);
    chk("t5_no_timeout_field", field_sel2, 4);
    chk("t5_no_timeout_run_en", run_en2, 0);
    cyc();

    // T6: full mode cycle, then reset in YEAR
    for (int k = 1; k <= 6; k++) begin
      btn_mode = 1'b1; cyc(); btn_mode = 1'b0;
      chk($sformatf("t6_cycle_%0d", k), field_sel, k % 6);
      cyc();
    end
    chk("t6_back_run_en", run_en, 1);
    for (int k = 0; k < 5; k++) begin
      btn_mode = 1'b1; cyc(); btn_mode = 1'b0; cyc();
    end
    chk("t6_year", field_sel, 5);
    rst = 1'b1; btn_up = 1'b1; cyc();
    chk("t6_rst_field", field_sel, 0);
    chk("t6_rst_run_en", run_en, 1);
    chk("t6_rst_en_yr", en_yr, 0);
    chk("t6_rst_up", up, 0);
    chk("t6_rst_sec_clr", sec_clr, 0);
    rst = 1'b0; cyc();
    chk("t6_post_rst_no_step", en_sum(), 0);
    btn_up = 1'b0; cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
